// File: rtl/fmap_writeback.sv
// Feature-map writeback: buffers pooled 48-bit beats and streams them to the RAM write port.
// Define FMAP_WRITEBACK_PERF_EN to add the saturating stall_cnt output.
module fmap_writeback #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [47:0]   m_data,
  input  logic          m_valid,
  output logic          m_ready,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] beat_cnt,
  input  logic          wr_stall,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [47:0]   wr_data,
  output logic          busy,
  output logic          done
`ifdef FMAP_WRITEBACK_PERF_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] CNT_ONE = AW'(1);
  localparam logic [PW:0]   PTR_ONE = (PW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [47:0]   fifo_mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW-1:0] base_reg, cnt_reg, accepted_reg, written_reg;
  logic          fifo_empty, fifo_full;
  logic          start_ok, push, pop, last_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                      (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);

  assign start_ok = (state_reg == ST_IDLE) && start;
  assign m_ready  = (state_reg == ST_RUN) && !fifo_full && (accepted_reg < cnt_reg);
  assign push     = m_valid && m_ready;
  assign pop      = (state_reg == ST_RUN) && !fifo_empty && !wr_stall;
  assign last_pop = pop && ((written_reg + CNT_ONE) == cnt_reg);

  assign busy = (state_reg != ST_IDLE);
  assign done = (state_reg == ST_DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (beat_cnt != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (last_pop) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Buffer storage has no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[PW-1:0]] <= m_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      base_reg     <= '0;
      cnt_reg      <= '0;
      accepted_reg <= '0;
      written_reg  <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        base_reg     <= base_addr;
        cnt_reg      <= beat_cnt;
        accepted_reg <= '0;
        written_reg  <= '0;
      end else begin
        if (push) begin
          accepted_reg <= accepted_reg + CNT_ONE;
        end
        if (pop) begin
          written_reg <= written_reg + CNT_ONE;
        end
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      // Address wraps naturally at 2^AW; address/data hold between writes.
      wr_en <= pop;
      if (pop) begin
        wr_addr <= base_reg + written_reg;
        wr_data <= fifo_mem[rd_ptr_reg[PW-1:0]];
      end
    end
  end

`ifdef FMAP_WRITEBACK_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if ((state_reg == ST_RUN) && !fifo_empty && wr_stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fmap_writeback.sv
// Bench for fmap_writeback: queue-based transaction model checked every cycle plus directed scenarios.
// Stall counter checks are compiled in when FMAP_WRITEBACK_PERF_EN is defined.
module tb_fmap_writeback;

  localparam int DEPTH = 4;
  localparam int AW    = 13;

  logic          clk = 1'b0;
  logic          rst, m_valid, m_ready, start, wr_stall, wr_en, busy, done;
  logic [47:0]   m_data, wr_data;
  logic [AW-1:0] base_addr, beat_cnt, wr_addr;
`ifdef FMAP_WRITEBACK_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  fmap_writeback #(.FIFO_DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .start(start), .base_addr(base_addr), .beat_cnt(beat_cnt), .wr_stall(wr_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
`ifdef FMAP_WRITEBACK_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: layer phase (0 idle, 1 run, 2 done), buffered beats, counters, expected outputs.
  int            mph, macc, mwr, mcnt, mbase, exp_stall;
  logic [47:0]   mq[$];
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [47:0]   exp_data;

  logic [47:0]   src[$];
  logic [47:0]   pat[$];
  int            valid_pct;
  int            cyc_n;
  int            done_cyc;
  logic [AW-1:0] got_addr[$];
  logic [47:0]   got_data[$];
  int            got_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic clear_log();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    done_cyc = -1;
  endtask

  // One clock: drive inputs, check m_ready, advance model, take edge, check registered outputs.
  task automatic step(input bit r, input bit st, input bit stall);
    logic exp_ready;
    bit   push, pop;
    rst      = r;
    start    = st;
    wr_stall = stall;
    m_valid  = (src.size() > 0) && ($urandom_range(99) < valid_pct);
    m_data   = (src.size() > 0) ? src[0] : 48'h0;
    exp_ready = (mph == 1) && (mq.size() < DEPTH) && (macc < mcnt);
    chk("m_ready", 64'(m_ready), 64'(exp_ready));
    if (r) begin
      mph = 0; mq.delete(); macc = 0; mwr = 0; mcnt = 0;
      exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_stall = 0;
    end else begin
      push = m_valid && exp_ready;
      pop  = (mph == 1) && (mq.size() > 0) && !stall;
      if (mph == 0 && st) exp_stall = 0;
      else if (mph == 1 && mq.size() > 0 && stall && exp_stall < 65535) exp_stall++;
      exp_we = pop;
      if (pop) begin
        exp_data = mq.pop_front();
        exp_addr = AW'((mbase + mwr) % (1 << AW));
        mwr++;
      end
      if (push) begin
        mq.push_back(m_data);
        macc++;
        src.delete(0);
      end
      case (mph)
        0: if (st) begin
             mbase = int'(base_addr); mcnt = int'(beat_cnt);
             macc = 0; mwr = 0;
             mph = (mcnt != 0) ? 1 : 2;
           end
        1: if (pop && mwr == mcnt) mph = 2;
        default: mph = 0;
      endcase
    end
    @(posedge clk);
    #1;
    cyc_n++;
    chk("wr_en", 64'(wr_en), 64'(exp_we));
    chk("wr_addr", 64'(wr_addr), 64'(exp_addr));
    chk("wr_data", 64'(wr_data), 64'(exp_data));
    chk("busy", 64'(busy), 64'(mph != 0));
    chk("done", 64'(done), 64'(mph == 2));
`ifdef FMAP_WRITEBACK_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif
    if (wr_en === 1'b1) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      got_cyc.push_back(cyc_n);
    end
    if (done === 1'b1) done_cyc = cyc_n;
  endtask

  task automatic run_until_idle(input int stall_pct, input int budget);
    int n = 0;
    while (mph != 0 && n < budget) begin
      step(1'b0, 1'b0, $urandom_range(99) < stall_pct);
      n++;
    end
    chk("layer_finished_in_budget", 64'(mph == 0), 64'd1);
  endtask

  task automatic load_beats(input int n);
    logic [47:0] b;
    pat.delete();
    src.delete();
    for (int i = 0; i < n; i++) begin
      b = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      pat.push_back(b);
      src.push_back(b);
    end
  endtask

  task automatic check_writes(input string tag, input int n, input int base);
    chk({tag, "_count"}, 64'(got_addr.size()), 64'(n));
    if (got_addr.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk({tag, "_addr"}, 64'(got_addr[i]), 64'((base + i) % (1 << AW)));
        chk({tag, "_data"}, 64'(got_data[i]), 64'(pat[i]));
      end
    end
  endtask

  initial begin
    int s, cnt, spct;
    rst = 1'b1; start = 1'b0; wr_stall = 1'b0; m_valid = 1'b0; m_data = '0;
    base_addr = '0; beat_cnt = '0;
    valid_pct = 100; cyc_n = 0;
    mph = 0; macc = 0; mwr = 0; mcnt = 0; mbase = 0; exp_stall = 0;
    exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    clear_log();
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("reset_m_ready", 64'(m_ready), 64'd0);

    // Three back-to-back beats, no stall
    clear_log(); load_beats(3);
    base_addr = 13'h010; beat_cnt = 13'd3;
    s = cyc_n;
    step(1'b0, 1'b1, 1'b0);
    run_until_idle(0, 50);
    check_writes("s1", 3, 16);
    if (got_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("s1_write_cycle", 64'(got_cyc[i]), 64'(s + 3 + i));
    end
    chk("s1_done_cycle", 64'(done_cyc), 64'(s + 5));

    // Ten stalled cycles with six beats offered
    clear_log(); load_beats(6);
    base_addr = 13'h100; beat_cnt = 13'd6;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b1);
    chk("s2_ready_low_when_full", 64'(m_ready), 64'd0);
    chk("s2_no_writes_while_stalled", 64'(got_addr.size()), 64'd0);
`ifdef FMAP_WRITEBACK_PERF_EN
    chk("s2_stall_cnt", 64'(stall_cnt), 64'd10);
`endif
    run_until_idle(0, 60);
    check_writes("s2", 6, 'h100);

    // Address wrap-around
    clear_log(); load_beats(4);
    base_addr = 13'h1FFE; beat_cnt = 13'd4;
    step(1'b0, 1'b1, 1'b0);
    run_until_idle(0, 50);
    check_writes("s3", 4, 'h1FFE);
    if (got_addr.size() == 4) chk("s3_wrapped_addr", 64'(got_addr[2]), 64'h0);

    // Zero-length layer
    clear_log(); load_beats(1);
    base_addr = 13'h020; beat_cnt = 13'd0;
    step(1'b0, 1'b1, 1'b0);
    chk("s4_done_next_cycle", 64'(done), 64'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("s4_done_one_cycle", 64'(done), 64'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("s4_no_writes", 64'(got_addr.size()), 64'd0);
    src.delete();

    // Extra beat refused; start during RUN ignored
    clear_log(); load_beats(5);
    base_addr = 13'h200; beat_cnt = 13'd4;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    base_addr = 13'h555; beat_cnt = 13'd2;
    step(1'b0, 1'b1, 1'b0);
    run_until_idle(0, 50);
    check_writes("s5", 4, 'h200);
    src.delete();

    // Reset with three beats buffered, start in the same cycle
    clear_log(); load_beats(8);
    base_addr = 13'h040; beat_cnt = 13'd8;
    step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("s6_wr_en_after_rst", 64'(wr_en), 64'd0);
    chk("s6_busy_after_rst", 64'(busy), 64'd0);
    src.delete();
    repeat (6) step(1'b0, 1'b0, 1'b0);
    chk("s6_no_writes", 64'(got_addr.size()), 64'd0);

    // Randomized layers
    for (int l = 0; l < 25; l++) begin
      clear_log();
      cnt = int'($urandom_range(0, 10));
      load_beats(cnt + int'($urandom_range(0, 2)));
      valid_pct = int'($urandom_range(40, 100));
      spct = int'($urandom_range(0, 50));
      base_addr = AW'($urandom);
      beat_cnt = AW'(cnt);
      s = int'(base_addr);
      step(1'b0, 1'b1, 1'b0);
      run_until_idle(spct, 400);
      check_writes("rand", cnt, s);
      src.delete();
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
